clk_div_prog: RTL and testbench

Parametrised, run-time programmable multi-channel clock divider. Each channel generates a 50%-duty divided clock from the single system clock `clk`. Each channel has its own divide ratio, enable, and glitch-free ratio update applied at a half-period boundary. It is the successor to the fixed 250 kHz / 1 kHz divider and feeds SPI SCLK generation and slow housekeeping timers.

---
 rtl/clk_div_prog.sv | 66 ++++++
 tb/tb_clk_div_prog.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable multi-channel 50%-duty clock divider with shadowed divisor updates.
// Optional CLK_DIV_PROG_TICK_EN adds a per-channel one-cycle tick after each clk_out rise.
module clk_div_prog #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 8,
  parameter int DIV_RST = 250,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              restart,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] div_pend,
  output logic [NUM_CH-1:0] clk_out
`ifdef CLK_DIV_PROG_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick
`endif
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr, tc, ap;
    logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
    logic clk_q, clk_d, pend_q, pend_d;
    // Shadow is only applied where no half-period is in flight: terminal count, disable or restart.
    always_comb begin
      wr = div_wr && div_data != '0 && 32'(div_ch) == g;
      tc = cnt_q == act_q - CNT_W'(1);
      ap = restart || !en[g] || tc;
      cnt_d = ap ? '0 : cnt_q + CNT_W'(1);
      clk_d = (restart || !en[g]) ? 1'b0 : clk_q ^ tc;
      act_d = (ap && pend_q) ? shd_q : act_q;
      shd_d = wr ? div_data : shd_q;
      pend_d = wr || (pend_q && !ap);
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        clk_q <= 1'b0;
        act_q <= CNT_W'(DIV_RST);
        shd_q <= CNT_W'(DIV_RST);
        pend_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        clk_q <= clk_d;
        act_q <= act_d;
        shd_q <= shd_d;
        pend_q <= pend_d;
      end
    end
    assign clk_out[g] = clk_q;
    assign div_pend[g] = pend_q;
`ifdef CLK_DIV_PROG_TICK_EN
    logic tick_q, tick_d;
    // clk_q high with cnt_q zero only occurs in the cycle right after a rising toggle.
    always_comb tick_d = en[g] && !restart && clk_q && cnt_q == '0;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) tick_q <= 1'b0;
      else tick_q <= tick_d;
    end
    assign tick[g] = tick_q;
`endif
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed plus randomized check of clk_div_prog against a countdown reference model.
module tb_clk_div_prog;
  localparam int NUM_CH = 3;
  localparam int CNT_W = 8;
  localparam int DIV_RST = 250;
  localparam int CH_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic div_wr = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic [CH_W-1:0] div_ch = '0;
  logic [CNT_W-1:0] div_data = '0;
  logic [NUM_CH-1:0] div_pend, clk_out;
`ifdef CLK_DIV_PROG_TICK_EN
  logic [NUM_CH-1:0] tick;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int m_act[NUM_CH], m_shd[NUM_CH], m_rem[NUM_CH];
  bit m_lvl[NUM_CH], m_pend[NUM_CH], m_rose[NUM_CH], m_tick[NUM_CH];

  clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .div_wr(div_wr),
    .div_ch(div_ch), .div_data(div_data), .div_pend(div_pend), .clk_out(clk_out)
`ifdef CLK_DIV_PROG_TICK_EN
    , .tick(tick)
`endif
  );

  always #5 clk = ~clk;

  // Model: each channel counts down the cycles left in the current half-period.
  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_act[c] = DIV_RST;
        m_shd[c] = DIV_RST;
        m_rem[c] = DIV_RST;
        m_lvl[c] = 0;
        m_pend[c] = 0;
        m_rose[c] = 0;
        m_tick[c] = 0;
      end else begin
        m_tick[c] = en[c] && !restart && m_rose[c];
        m_rose[c] = 0;
        if (restart || !en[c]) begin
          if (m_pend[c]) begin
            m_act[c] = m_shd[c];
            m_pend[c] = 0;
          end
          m_lvl[c] = 0;
          m_rem[c] = m_act[c];
        end else begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_lvl[c] = !m_lvl[c];
            m_rose[c] = m_lvl[c];
            if (m_pend[c]) begin
              m_act[c] = m_shd[c];
              m_pend[c] = 0;
            end
            m_rem[c] = m_act[c];
          end
        end
        if (div_wr && div_data != 0 && int'(div_ch) == c) begin
          m_shd[c] = int'(div_data);
          m_pend[c] = 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int e_clk, e_pend, e_tick;
    @(negedge clk);
    e_clk = 0;
    e_pend = 0;
    e_tick = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      e_clk |= int'(m_lvl[c]) << c;
      e_pend |= int'(m_pend[c]) << c;
      e_tick |= int'(m_tick[c]) << c;
    end
    chk("model_clk_out", int'(clk_out), e_clk);
    chk("model_div_pend", int'(div_pend), e_pend);
`ifdef CLK_DIV_PROG_TICK_EN
    chk("model_tick", int'(tick), e_tick);
`endif
  endtask

  task automatic wr(input int ch, input int data);
    div_wr = 1'b1;
    div_ch = CH_W'(ch);
    div_data = CNT_W'(data);
    step();
    div_wr = 1'b0;
  endtask

  task automatic run_until(input int ch, input bit val, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out[ch] !== val && n < 3000);
    if (n >= 3000) chk("timeout", 0, 1);
  endtask

  initial begin
    int n, nco, nt;
    bit p0, p1;
    repeat (3) @(negedge clk);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_div_pend", int'(div_pend), 0);
    rst = 1'b0;
    en = 3'b111;
    run_until(0, 1, n);
    chk("first_rise", n, 250);
    chk("first_rise_ch1", int'(clk_out[1]), 1);
    repeat (100) step();
    wr(0, 4);
    chk("pend0_set", int'(div_pend[0]), 1);
    run_until(0, 0, n);
    chk("old_boundary", n, 149);
    chk("pend0_clr", int'(div_pend[0]), 0);
    run_until(0, 1, n);
    chk("h4_low", n, 4);
    run_until(0, 0, n);
    chk("h4_high", n, 4);
    wr(1, 0);
    wr(3, 77);
    chk("bad_wr_pend", int'(div_pend), 0);
    wr(1, 10);
    wr(1, 6);
    chk("two_wr_pend", int'(div_pend), 3'b010);
    run_until(1, 1, n);
    chk("pend1_clr", int'(div_pend[1]), 0);
    run_until(1, 0, n);
    chk("last_wr_wins", n, 6);
    wr(1, 5);
    repeat (4) step();
    wr(1, 9);
    chk("same_cycle_pend", int'(div_pend[1]), 1);
    run_until(1, 0, n);
    chk("h5_high", n, 5);
    run_until(1, 1, n);
    chk("h9_low", n, 9);
    chk("h9_pend_clr", int'(div_pend[1]), 0);
    wr(0, 2);
    wr(1, 6);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_clk", int'(clk_out), 0);
    chk("restart_pend", int'(div_pend), 0);
    nco = 0;
    p0 = 0;
    p1 = 0;
    repeat (24) begin
      step();
      if (clk_out[0] && !p0 && clk_out[1] && !p1) nco++;
      p0 = clk_out[0];
      p1 = clk_out[1];
    end
    chk("coincident_rises", nco, 2);
    en[0] = 1'b0;
    repeat (3) step();
    chk("disable_clk0", int'(clk_out[0]), 0);
    en[0] = 1'b1;
    run_until(0, 1, n);
    chk("reenable_rise", n, 2);
    run_until(1, 1, n);
    step();
    #2 rst = 1'b1;
    #1 chk("async_rst_clk", int'(clk_out), 0);
    chk("async_rst_pend", int'(div_pend), 0);
    @(negedge clk);
    rst = 1'b0;
    wr(0, 3);
    en[0] = 1'b0;
    step();
    en[0] = 1'b1;
    nt = 0;
    repeat (60) begin
      step();
`ifdef CLK_DIV_PROG_TICK_EN
      if (tick[0]) nt++;
`else
      if (clk_out[0] && !p0) nt++;
      p0 = clk_out[0];
`endif
    end
    chk("h3_pulses", nt, 10);
    repeat (4000) begin
      for (int c = 0; c < NUM_CH; c++) en[c] = $urandom_range(0, 15) != 0;
      restart = $urandom_range(0, 39) == 0;
      div_wr = $urandom_range(0, 5) == 0;
      div_ch = CH_W'($urandom_range(0, 3));
      div_data = CNT_W'($urandom_range(0, 7));
      step();
    end
    div_wr = 1'b0;
    restart = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
